// File: rtl/calc_pkg.sv
// Shared types and constants for the sequential calculator core.
// Divider hardware is present only when CALC_DIV_EN is defined.
package calc_pkg;

    typedef enum logic [1:0] {
        FCT_ADD = 2'b00,
        FCT_SUB = 2'b01,
        FCT_MUL = 2'b10,
        FCT_DIV = 2'b11
    } fct_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Replicated across the full result on divide by zero.
    localparam logic CALC_DIVZERO_FILL = 1'b1;

endpackage

// File: rtl/calc_muldiv.sv
// Iterative shift-add multiplier and restoring divider, one bit per step.
// The divide path exists only when CALC_DIV_EN is defined.
module calc_muldiv
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
`ifdef CALC_DIV_EN
    input  logic               div,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               last,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   opb;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     sum;
`ifdef CALC_DIV_EN
    logic               div_q;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   rem;
    logic               ge;
`endif

    assign last   = (cnt == LAST);
    assign result = acc_d;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, quotient}.
    always_comb begin
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        acc_d = {sum, acc[WIDTH-1:1]};
`ifdef CALC_DIV_EN
        shifted = acc[2*WIDTH-1:WIDTH-1];
        ge      = (shifted >= {1'b0, opb});
        rem     = shifted[WIDTH-1:0] - opb;
        if (div_q) begin
            acc_d = {(ge ? rem : shifted[WIDTH-1:0]), acc[WIDTH-2:0], ge};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            opb <= '0;
            cnt <= '0;
`ifdef CALC_DIV_EN
            div_q <= 1'b0;
`endif
        end else if (load) begin
            cnt <= '0;
`ifdef CALC_DIV_EN
            div_q <= div;
            if (div) begin
                acc <= {{WIDTH{1'b0}}, a};
                opb <= b;
            end else begin
                acc <= {{WIDTH{1'b0}}, b};
                opb <= a;
            end
`else
            acc <= {{WIDTH{1'b0}}, b};
            opb <= a;
`endif
        end else if (step) begin
            acc <= acc_d;
            if (!last) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/calc_seq_core.sv
// Handshaked calculator core: FSM, operand/result registers, add/sub path.
// Define CALC_DIV_EN to build the divider; otherwise div reports an error.
module calc_seq_core
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    output logic               ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [1:0]         fct_i,
    output logic [2*WIDTH-1:0] s_o,
    output logic               signal_o,
    output logic               err_o,
    output logic               done_o,
    input  logic               ack_i
);

    state_e             state_q;
    state_e             state_d;
    fct_e               fct_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               load;
    logic               step;
    logic               md_last;
    logic [2*WIDTH-1:0] md_res;
    logic               wr;
    logic [2*WIDTH-1:0] res_d;
    logic               sig_d;
    logic               err_d;
    logic [WIDTH:0]     sum_ab;
    logic [WIDTH-1:0]   diff_ab;
    logic               lt_ab;

    assign sum_ab  = {1'b0, a_q} + {1'b0, b_q};
    assign lt_ab   = (a_q < b_q);
    assign diff_ab = lt_ab ? (b_q - a_q) : (a_q - b_q);

    calc_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clock_i),
        .rst_n  (reset_i),
        .load   (load),
        .step   (step),
`ifdef CALC_DIV_EN
        .div    (fct_i == FCT_DIV),
`endif
        .a      (a_i),
        .b      (b_i),
        .last   (md_last),
        .result (md_res)
    );

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        done_o  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        wr      = 1'b0;
        res_d   = '0;
        sig_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    load    = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                unique case (fct_q)
                    FCT_ADD: begin
                        wr    = 1'b1;
                        res_d = {{(WIDTH-1){1'b0}}, sum_ab};
                    end
                    FCT_SUB: begin
                        wr    = 1'b1;
                        res_d = {{WIDTH{1'b0}}, diff_ab};
                        sig_d = lt_ab;
                    end
                    FCT_MUL: begin
                        step  = 1'b1;
                        wr    = md_last;
                        res_d = md_res;
                    end
                    FCT_DIV: begin
`ifdef CALC_DIV_EN
                        if (b_q == '0) begin
                            wr    = 1'b1;
                            err_d = 1'b1;
                            res_d = {(2*WIDTH){CALC_DIVZERO_FILL}};
                        end else begin
                            step  = 1'b1;
                            wr    = md_last;
                            res_d = md_res;
                        end
`else
                        wr    = 1'b1;
                        err_d = 1'b1;
`endif
                    end
                    default: ;
                endcase
                if (wr) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o = 1'b1;
                if (ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            a_q   <= '0;
            b_q   <= '0;
            fct_q <= FCT_ADD;
        end else if (load) begin
            a_q   <= a_i;
            b_q   <= b_i;
            fct_q <= fct_e'(fct_i);
        end
    end

    // Result only changes on the final execute cycle, never mid-sequence.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            s_o      <= '0;
            signal_o <= 1'b0;
            err_o    <= 1'b0;
        end else if (wr) begin
            s_o      <= res_d;
            signal_o <= sig_d;
            err_o    <= err_d;
        end
    end

endmodule
